shift_add_multiplier: RTL and testbench

Sequential unsigned N×N multiplier that produces a 2N-bit product by shift-and-add over N clock cycles. Each cycle it issues one partial-product addition to an internal `parallel_adder` instance (width N) and consumes that adder's sum and carry-out. It is the first multi-cycle arithmetic stage built on the ripple adder library. It serves datapaths that trade latency for area.

---
 rtl/shift_add_multiplier.sv | 147 ++++++++++++++
 tb/tb_shift_add_multiplier.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N shift-and-add multiplier producing a 2N-bit product.
// One partial-product addition per cycle through a ripple-carry parallel_adder.

module parallel_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);
  logic [N:0] w_carry;

  assign w_carry[0] = i_cin;

  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    assign o_sum[gi]      = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
    assign w_carry[gi+1]  = (i_a[gi] & i_b[gi]) | (w_carry[gi] & (i_a[gi] ^ i_b[gi]));
  end

  assign o_cout = w_carry[N];
endmodule

module shift_add_multiplier #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [N-1:0]   r_mcand;
  logic [N-1:0]   r_acc_hi;
  logic [N-1:0]   r_acc_lo;
  logic [CW-1:0]  r_count;
  logic [2*N-1:0] r_product;

  logic [N-1:0]   w_sum;
  logic           w_cout;
  logic [N-1:0]   w_hi_next;
  logic [N-1:0]   w_lo_next;
  logic           w_last;

  parallel_adder #(.N(N)) u_adder (
    .i_a    (r_acc_hi),
    .i_b    (r_mcand),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // The carry-out is the only bit that can enter the top of the accumulator.
  always_comb begin
    w_hi_next = {1'b0, r_acc_hi[N-1:1]};
    w_lo_next = {r_acc_hi[0], r_acc_lo[N-1:1]};
    if (r_acc_lo[0]) begin
      w_hi_next = {w_cout, w_sum[N-1:1]};
      w_lo_next = {w_sum[0], r_acc_lo[N-1:1]};
    end
  end

  assign w_last = (r_count == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand   <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand  <= a;
            r_acc_lo <= b;
            r_acc_hi <= '0;
            r_count  <= '0;
          end
        end
        RUN: begin
          r_acc_hi <= w_hi_next;
          r_acc_lo <= w_lo_next;
          r_count  <= r_count + CW'(1);
          // Capture the post-shift value so the result is ready on the same edge.
          if (w_last) begin
            r_product <= {w_hi_next, w_lo_next};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign product = r_product;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench: N=4 and N=8 multipliers checked every cycle against a
// cycle-count/arithmetic reference model, plus literal expected products.

module tb_shift_add_multiplier;
  logic        clk = 1'b0;
  logic        rst4, start4;
  logic [3:0]  a4, b4;
  logic        busy4, done4;
  logic [7:0]  product4;
  logic        rst8, start8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] product8;

  int tests = 0;
  int fails = 0;
  bit stim_over = 1'b0;

  longint lit4[$];
  longint lit8[$];

  // Reference model state: remaining RUN cycles, DONE flag, held/pending product.
  int     left   [2];
  bit     indone [2];
  longint mprod  [2];
  longint mpend  [2];
  int     width  [2];

  always #5 clk = ~clk;

  shift_add_multiplier #(.N(4)) u_mul4 (
    .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(product4)
  );

  shift_add_multiplier #(.N(8)) u_mul8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(product8)
  );

  task automatic model_step(input int i, input bit r, input bit s,
                            input longint av, input longint bv);
    if (r) begin
      left[i] = 0; indone[i] = 1'b0; mprod[i] = 0;
    end else if (indone[i]) begin
      indone[i] = 1'b0;
    end else if (left[i] > 0) begin
      left[i] = left[i] - 1;
      if (left[i] == 0) begin
        mprod[i]  = mpend[i];
        indone[i] = 1'b1;
      end
    end else if (s) begin
      left[i]  = width[i];
      mpend[i] = av * bv;
    end
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0d, required %0d", name, $time, act, exp);
    end
  endtask

  initial begin
    width[0] = 4; width[1] = 8;
    for (int i = 0; i < 2; i++) begin
      left[i] = 0; indone[i] = 1'b0; mprod[i] = 0; mpend[i] = 0;
    end
  end

  // Single compare process: advance model on each edge, check outputs 1 time unit later.
  always @(posedge clk) begin
    model_step(0, rst4, start4, longint'(a4), longint'(b4));
    model_step(1, rst8, start8, longint'(a8), longint'(b8));
    #1;
    check("busy4", longint'(busy4), longint'(left[0] > 0));
    check("done4", longint'(done4), longint'(indone[0]));
    check("product4", longint'(product4), mprod[0]);
    check("busy8", longint'(busy8), longint'(left[1] > 0));
    check("done8", longint'(done8), longint'(indone[1]));
    check("product8", longint'(product8), mprod[1]);
    if (indone[0]) begin
      $display("[TB] N=4 done product=%0d (model %0d)", product4, mprod[0]);
      if (lit4.size() > 0) check("literal4", longint'(product4), lit4.pop_front());
    end
    if (indone[1]) begin
      $display("[TB] N=8 done product=%0d (model %0d)", product8, mprod[1]);
      if (lit8.size() > 0) check("literal8", longint'(product8), lit8.pop_front());
    end
    if (stim_over) begin
      check("literal4_drained", longint'(lit4.size()), 0);
      check("literal8_drained", longint'(lit8.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  task automatic go4(input logic [3:0] av, input logic [3:0] bv, input longint exp);
    lit4.push_back(exp);
    @(negedge clk); start4 = 1'b1; a4 = av; b4 = bv;
    @(negedge clk); start4 = 1'b0;
    repeat (7) @(negedge clk);
  endtask

  task automatic go8(input logic [7:0] av, input logic [7:0] bv, input longint exp);
    lit8.push_back(exp);
    @(negedge clk); start8 = 1'b1; a8 = av; b8 = bv;
    @(negedge clk); start8 = 1'b0;
    repeat (11) @(negedge clk);
  endtask

  initial begin
    rst4 = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0;
    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    rst4 = 1'b0; rst8 = 1'b0;
    @(negedge clk);

    go4(4'd3, 4'd5, 15);
    go4(4'd15, 4'd15, 225);
    go4(4'd0, 4'd9, 0);
    go4(4'd9, 4'd0, 0);

    // start held through RUN and DONE: second operands accepted right after DONE
    lit4.push_back(42);
    lit4.push_back(1);
    @(negedge clk); start4 = 1'b1; a4 = 4'd6; b4 = 4'd7;
    @(negedge clk); a4 = 4'd1; b4 = 4'd1;
    repeat (6) @(negedge clk);
    start4 = 1'b0;
    repeat (8) @(negedge clk);

    // reset asserted two edges into the run aborts it
    @(negedge clk); start4 = 1'b1; a4 = 4'd13; b4 = 4'd11;
    @(negedge clk); start4 = 1'b0;
    @(negedge clk); rst4 = 1'b1;
    @(negedge clk); rst4 = 1'b0;
    repeat (6) @(negedge clk);
    go4(4'd2, 4'd3, 6);

    go8(8'd255, 8'd255, 65025);
    go8(8'd128, 8'd2, 256);

    // randomized traffic on both instances with occasional reset
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      start4 = 1'($urandom_range(0, 3) == 0);
      a4     = 4'($urandom);
      b4     = 4'($urandom);
      rst4   = 1'($urandom_range(0, 63) == 0);
      start8 = 1'($urandom_range(0, 3) == 0);
      a8     = 8'($urandom);
      b8     = 8'($urandom);
      rst8   = 1'($urandom_range(0, 63) == 0);
    end
    @(negedge clk);
    start4 = 1'b0; start8 = 1'b0; rst4 = 1'b0; rst8 = 1'b0;
    repeat (12) @(negedge clk);
    stim_over = 1'b1;
  end
endmodule
